// File: rtl/croc_sram_bank_arbiter.sv
// Round-robin share of one 1-cycle-latency SRAM bank among NumReq OBI requesters; grant is combinational, response 1 cycle later.
// Backpressure: a requester holds req until gnt; one access is granted per cycle, and losers wait for their round-robin turn.
module croc_sram_bank_arbiter #(
  parameter int unsigned          NumReq    = 4,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          IdWidth   = 3,
  parameter logic [AddrWidth-1:0] BankBase  = 'h1000_0000,
  parameter int unsigned          BankWords = 512,
  localparam int unsigned         BankAw    = (BankWords > 1) ? $clog2(BankWords) : 1,
  localparam int unsigned         BeWidth   = DataWidth / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              req_i,
  input  logic [NumReq-1:0]              we_i,
  input  logic [NumReq*AddrWidth-1:0]    addr_i,
  input  logic [NumReq*DataWidth-1:0]    wdata_i,
  input  logic [NumReq*BeWidth-1:0]      be_i,
  input  logic [NumReq*IdWidth-1:0]      aid_i,
  output logic [NumReq-1:0]              gnt_o,
  output logic [NumReq-1:0]              rvalid_o,
  output logic [DataWidth-1:0]           rdata_o,
  output logic [IdWidth-1:0]             rid_o,
  output logic                           err_o,
  output logic                           sram_req_o,
  output logic                           sram_we_o,
  output logic [BankAw-1:0]              sram_addr_o,
  output logic [DataWidth-1:0]           sram_wdata_o,
  output logic [BeWidth-1:0]             sram_be_o,
  input  logic [DataWidth-1:0]           sram_rdata_i,
  input  logic                           cnt_clr_i,
  output logic [15:0]                    conflict_cnt_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  // Range compare is done wide enough that BankBase + size can never wrap.
  localparam int unsigned CmpW = AddrWidth + 34;
  localparam logic [CmpW-1:0] BankBytes = CmpW'(BankWords) << 2;

  typedef struct packed {
    logic [IdxW-1:0]    idx;
    logic [IdWidth-1:0] id;
    logic               err;
    logic               we;
  } resp_t;

  logic [AddrWidth-1:0] addr_arr  [NumReq];
  logic [DataWidth-1:0] wdata_arr [NumReq];
  logic [BeWidth-1:0]   be_arr    [NumReq];
  logic [IdWidth-1:0]   aid_arr   [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign addr_arr[g]  = addr_i[g*AddrWidth +: AddrWidth];
    assign wdata_arr[g] = wdata_i[g*DataWidth +: DataWidth];
    assign be_arr[g]    = be_i[g*BeWidth +: BeWidth];
    assign aid_arr[g]   = aid_i[g*IdWidth +: IdWidth];
  end

  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] rr_nxt;
  logic [IdxW:0]   cand;
  logic [IdxW:0]   rr_inc;
  logic            found;
  logic [IdxW-1:0] winner;

  resp_t           resp_q;
  logic            resp_valid_q;
  logic [15:0]     cnt_q;

  // Scan starts at rr_q and wraps, so the last winner has lowest priority next time.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = {1'b0, rr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumReq)) begin
        cand = cand - (IdxW+1)'(NumReq);
      end
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    rr_inc = {1'b0, winner} + (IdxW+1)'(1);
    rr_nxt = (rr_inc >= (IdxW+1)'(NumReq)) ? '0 : rr_inc[IdxW-1:0];
  end

  logic [AddrWidth-1:0] w_addr;
  logic [AddrWidth-1:0] off;
  logic                 w_we;
  logic                 in_range;

  assign w_addr   = addr_arr[winner];
  assign w_we     = we_i[winner];
  assign off      = w_addr - BankBase;
  assign in_range = (w_addr >= BankBase) && (CmpW'(off) < BankBytes);

  always_comb begin
    gnt_o = '0;
    if (found) begin
      gnt_o[winner] = 1'b1;
    end
  end

  assign sram_req_o   = found & in_range;
  assign sram_we_o    = sram_req_o & w_we;
  assign sram_addr_o  = found ? off[BankAw+1:2] : '0;
  assign sram_wdata_o = found ? wdata_arr[winner] : '0;
  assign sram_be_o    = found ? be_arr[winner] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      resp_valid_q <= found;
      if (found) begin
        rr_q   <= rr_nxt;
        resp_q <= '{idx: winner, id: aid_arr[winner], err: !in_range, we: w_we};
      end
    end
  end

  // Writes and out-of-bank accesses return zero data rather than stale SRAM output.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    rid_o    = '0;
    err_o    = 1'b0;
    if (resp_valid_q) begin
      rvalid_o[resp_q.idx] = 1'b1;
      rid_o                = resp_q.id;
      err_o                = resp_q.err;
      if (!resp_q.err && !resp_q.we) begin
        rdata_o = sram_rdata_i;
      end
    end
  end

  logic multi_req;
  assign multi_req = |(req_i & (req_i - NumReq'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (multi_req && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule
